// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Drives all input rows of an N-input boolean unit, captures its
//               truth table and compares it against an expected minterm mask.
// Revision    : 1.0  initial release
// ============================================================================
module truth_table_sweeper #(
  parameter int N_VARS = 3,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [2**N_VARS-1:0]   i_expected,
  output logic [N_VARS-1:0]      o_vars,
  input  logic                   i_s_in,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [2**N_VARS-1:0]   o_table_out,
  output logic [N_VARS:0]        o_zero_count,
  output logic                   o_match,
  output logic                   o_bad_valid,
  output logic [N_VARS-1:0]      o_first_bad
);

  localparam int ROWS = 2**N_VARS;
  localparam int ZW   = N_VARS + 1;
  localparam logic [N_VARS-1:0] c_LAST_IDX = N_VARS'(ROWS - 1);
  localparam logic [3:0]        c_SETTLE   = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [N_VARS-1:0] r_idx;
  logic [3:0]        r_cnt;
  logic [ROWS-1:0]   r_exp;
  logic [N_VARS-1:0] r_vars;
  logic              r_busy;
  logic              r_done;
  logic [ROWS-1:0]   r_table;
  logic [ZW-1:0]     r_zero_count;
  logic              r_match;
  logic              r_bad_valid;
  logic [N_VARS-1:0] r_first_bad;

  logic              w_accept;
  logic [ROWS-1:0]   w_diff;
  logic [ZW-1:0]     w_zeros;
  logic [N_VARS-1:0] w_first_bad;

  // busy is still high in the done cycle, so start there is not accepted
  assign w_accept = (r_state == S_IDLE) && i_start && !r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_WAIT;
      S_WAIT:   if (r_cnt == 4'd0) w_next = S_SAMPLE;
      S_SAMPLE: w_next = (r_idx == c_LAST_IDX) ? S_FINISH : S_WAIT;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Scan from the top so the lowest mismatching row wins
  always_comb begin
    w_diff      = r_table ^ r_exp;
    w_zeros     = '0;
    w_first_bad = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      w_zeros = w_zeros + ZW'(~r_table[i]);
      if (w_diff[i]) w_first_bad = N_VARS'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_cnt        <= '0;
      r_exp        <= '0;
      r_vars       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_table      <= '0;
      r_zero_count <= '0;
      r_match      <= 1'b0;
      r_bad_valid  <= 1'b0;
      r_first_bad  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_exp   <= i_expected;
            r_idx   <= '0;
            r_vars  <= '0;
            r_cnt   <= c_SETTLE;
            r_busy  <= 1'b1;
            r_table <= '0;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        S_SAMPLE: begin
          r_table[r_idx] <= i_s_in;
          if (r_idx != c_LAST_IDX) begin
            r_idx  <= r_idx + 1'b1;
            r_vars <= r_idx + 1'b1;
            r_cnt  <= c_SETTLE;
          end
        end
        S_FINISH: begin
          r_zero_count <= w_zeros;
          r_match      <= ~|w_diff;
          r_bad_valid  <= |w_diff;
          r_first_bad  <= w_first_bad;
          r_done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_vars       = r_vars;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_table_out  = r_table;
  assign o_zero_count = r_zero_count;
  assign o_match      = r_match;
  assign o_bad_valid  = r_bad_valid;
  assign o_first_bad  = r_first_bad;

endmodule
`default_nettype wire

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer for a 2..6-input combinational boolean unit, e.g. the 3-input product-of-sums function f = PoS(1,3,6,7).
- On start it drives every input combination 0..2^N-1 in ascending order and waits a settle time. It then samples the function output and builds the captured truth table.
- After the sweep it compares the table to an expected minterm mask and reports the maxterm count and the first mismatch.
- Sits between a test/config host and the function under evaluation. It replaces a hand-written stimulus sweep.

Parameters:
- N_VARS, 3, number of function inputs; legal 2..6.
- SETTLE, 1, wait cycles between driving inputs and sampling the output; legal 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; accepted only in IDLE.
- expected  input  2^N_VARS  expected minterm mask; bit i = required output for input i. Latched on start accept.
- vars  output  N_VARS  drives the function inputs; MSB = first variable (x), LSB = last (z).
- s_in  input  1  function output, sampled in SAMPLE.
- busy  output  1  high from start accept until the done cycle inclusive.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
- table_out  output  2^N_VARS  captured truth table; bit i = s_in sampled while vars == i.
- zero_count  output  N_VARS+1  number of 0 entries in table_out (maxterm count).
- match  output  1  1 when table_out == latched expected.
- bad_valid  output  1  1 when any bit mismatches.
- first_bad  output  N_VARS  lowest mismatching index; 0 when bad_valid = 0.

Behaviour:
- Reset, asynchronous and active-low, forces:
  - state to IDLE;
  - vars, busy, done, table_out, zero_count, match, bad_valid and first_bad all to 0;
  - the internal index, settle counter and latched expected value to 0.
- States: IDLE, WAIT, SAMPLE, FINISH.
- IDLE:
  - when start = 1, latch expected, set idx = 0, vars = 0, cnt = SETTLE, busy = 1, clear table_out, then go to WAIT;
  - otherwise hold all result outputs.
- WAIT: if cnt == 0 go to SAMPLE, else decrement cnt.
- SAMPLE:
  - table_out[idx] <= s_in;
  - if idx == 2^N_VARS-1, go to FINISH;
  - else increment idx, set vars = idx+1 (same edge), set cnt = SETTLE, then go to WAIT.
- Timing:
  - each row occupies SETTLE+2 cycles (WAIT counts SETTLE down to 0, then SAMPLE).
  - vars is stable for that whole window.
- FINISH:
  - register zero_count, match, bad_valid and first_bad, all computed from the final table and the latched expected mask;
  - assert done for exactly 1 cycle, then go to IDLE;
  - busy falls on the edge after done.
- Latency: the done cycle begins 2^N_VARS*(SETTLE+2)+1 edges after the start-accept edge. For N=3, SETTLE=1 this is 25.
- start while busy is ignored, with no restart and no queueing. start held high in the done cycle is not accepted; it is accepted on the next IDLE cycle.
- expected changing mid-sweep has no effect.
- vars holds its last value (2^N_VARS-1) in IDLE after a sweep.
- Results hold until the next start accept; table_out clears on accept.
- first_bad uses the lowest-index priority.
- Reset mid-sweep aborts immediately with no done pulse; all outputs follow the reset values above.
- zero_count arithmetic: the all-zero table gives 2^N_VARS. N_VARS+1 bits are sufficient.

Test Plan:
1. s_in = PoS(1,3,6,7) of vars, expected = 8'h35, SETTLE = 1 -> vars steps 0..7, done 25 edges after start; table_out = 8'h35, zero_count = 4, match = 1, bad_valid = 0, first_bad = 0.
2. Same function, expected = 8'h34 -> match = 0, bad_valid = 1, first_bad = 0, zero_count = 4.
3. Same function, expected = 8'h15 -> first_bad = 5 (lowest mismatch); expected = 8'hB5 -> first_bad = 7.
4. Pulse start again at cycle 6 of a sweep and change expected mid-sweep -> single done at edge 25, result uses the original expected, no second sweep.
5. rst_n low for 1 cycle at edge 10 of a sweep -> all outputs 0 immediately, no done; a new start then gives a full correct sweep.
6. SETTLE = 0, s_in tied 0, expected = 0 -> done 17 edges after start, table_out = 0, zero_count = 8, match = 1; s_in tied 1 -> zero_count = 0, table_out = 8'hFF.
